trace_sequencer: RTL and testbench



---
 rtl/dtb_pkg.sv | 16 +
 rtl/trb_addr_counter.sv | 36 +++
 rtl/trace_sequencer.sv | 141 ++++++++++++++
 tb/tb_trace_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dtb_pkg.sv
// Shared Data Trace Buffer definitions: trace memory geometry and the
// trace session controller state encoding.
package dtb_pkg;

   localparam int unsigned TRB_DEPTH  = 16;
   localparam int unsigned TRB_ADDR_W = $clog2(TRB_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRETRIG,
      ST_POSTTRIG,
      ST_STREAM,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/trb_addr_counter.sv
// Circular trace memory address counter with clear, increment and a sticky
// flag recording that the address has wrapped at least once.
module trb_addr_counter
   import dtb_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_inc,
   output logic [TRB_ADDR_W-1:0] o_addr,
   output logic                  o_wrapped
);

   logic [TRB_ADDR_W-1:0] r_addr;
   logic                  r_wrapped;

   // Clear wins over increment so a new session always starts at word 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr    <= '0;
         r_wrapped <= 1'b0;
      end else if (i_clr) begin
         r_addr    <= '0;
         r_wrapped <= 1'b0;
      end else if (i_inc) begin
         r_addr <= r_addr + TRB_ADDR_W'(1);
         if (r_addr == TRB_ADDR_W'(TRB_DEPTH - 1)) begin
            r_wrapped <= 1'b1;
         end
      end
   end

   assign o_addr    = r_addr;
   assign o_wrapped = r_wrapped;

endmodule

// File: rtl/trace_sequencer.sv
// Trace session controller: arms the Tracer, steps the circular buffer
// address on store/load pulses and ends the capture after the post-trigger count.
module trace_sequencer
   import dtb_pkg::*;
(
   input  logic                  FPGA_CLK_I,
   input  logic                  RST_I,
   input  logic                  ARM_I,
   input  logic                  STOP_I,
   input  logic                  MODE_I,
   input  logic [TRB_ADDR_W-1:0] DELAY_I,
   input  logic                  TRG_EVENT_I,
   input  logic                  STORE_I,
   input  logic                  LOAD_I,
   output logic                  EN_O,
   output logic                  MODE_O,
   output logic                  TRG_DELAYED_O,
   output logic [TRB_ADDR_W-1:0] ADDR_O,
   output logic                  WE_O,
   output logic [TRB_ADDR_W-1:0] TRG_ADDR_O,
   output logic                  WRAPPED_O,
   output logic                  BUSY_O,
   output logic                  DONE_O
);

   seq_state_t            r_state;
   seq_state_t            w_state_nxt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_mode;
   logic                  r_delayed;
   logic [TRB_ADDR_W-1:0] r_trg_addr;
   logic [TRB_ADDR_W-1:0] r_cnt;
   logic [TRB_ADDR_W-1:0] w_addr;
   logic                  w_wrapped;
   logic                  w_arm;
   logic                  w_we;
   logic                  w_load;
   logic                  w_trig;
   logic                  w_dec;
   logic                  w_expire;

   always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
      if (RST_I) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // STOP_I outranks trigger/count/load, but a coincident store is still written.
   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_we        = 1'b0;
      w_load      = 1'b0;
      w_trig      = 1'b0;
      w_dec       = 1'b0;
      w_expire    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (ARM_I) begin
               w_arm       = 1'b1;
               w_state_nxt = MODE_I ? ST_STREAM : ST_PRETRIG;
            end
         end
         ST_PRETRIG: begin
            w_we = STORE_I;
            if (STOP_I) begin
               w_state_nxt = ST_DONE;
            end else if (TRG_EVENT_I) begin
               w_trig      = 1'b1;
               w_state_nxt = ST_POSTTRIG;
            end
         end
         ST_POSTTRIG: begin
            w_we = STORE_I;
            if (STOP_I) begin
               w_state_nxt = ST_DONE;
            end else if (STORE_I) begin
               if (r_cnt == '0) begin
                  w_expire    = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_dec = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (STOP_I) w_state_nxt = ST_DONE;
            else        w_load      = LOAD_I;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Session flags follow the next state so they settle one cycle after the event.
   always_ff @(posedge FPGA_CLK_I or posedge RST_I) begin
      if (RST_I) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mode     <= 1'b0;
         r_delayed  <= 1'b0;
         r_trg_addr <= '0;
         r_cnt      <= '0;
      end else begin
         r_busy <= (w_state_nxt == ST_PRETRIG) || (w_state_nxt == ST_POSTTRIG) ||
                   (w_state_nxt == ST_STREAM);
         r_done <= (w_state_nxt == ST_DONE);
         if (w_arm) begin
            r_mode     <= MODE_I;
            r_delayed  <= 1'b0;
            r_trg_addr <= '0;
         end
         if (w_trig) begin
            r_trg_addr <= w_addr;
            r_cnt      <= DELAY_I;
         end else if (w_dec) begin
            r_cnt <= r_cnt - TRB_ADDR_W'(1);
         end
         if (w_expire) r_delayed <= 1'b1;
      end
   end

   trb_addr_counter u_addr_counter (
      .i_clk     (FPGA_CLK_I),
      .i_rst     (RST_I),
      .i_clr     (w_arm),
      .i_inc     (w_we | w_load),
      .o_addr    (w_addr),
      .o_wrapped (w_wrapped)
   );

   assign EN_O          = r_busy;
   assign BUSY_O        = r_busy;
   assign DONE_O        = r_done;
   assign MODE_O        = r_mode;
   assign TRG_DELAYED_O = r_delayed;
   assign TRG_ADDR_O    = r_trg_addr;
   assign ADDR_O        = w_addr;
   assign WRAPPED_O     = w_wrapped;
   assign WE_O          = w_we;

endmodule

// File: tb/tb_trace_sequencer.sv
// Scoreboard bench for trace_sequencer: directed session scenarios plus random
// traffic, checked cycle by cycle against a session-level reference model.
module tb_trace_sequencer;
   import dtb_pkg::*;

   localparam int DEPTH    = 16;
   localparam int P_IDLE   = 0;
   localparam int P_PRE    = 1;
   localparam int P_POST   = 2;
   localparam int P_STREAM = 3;
   localparam int P_DONE   = 4;

   logic                  FPGA_CLK_I = 1'b0;
   logic                  RST_I = 1'b1;
   logic                  ARM_I = 1'b0;
   logic                  STOP_I = 1'b0;
   logic                  MODE_I = 1'b0;
   logic [TRB_ADDR_W-1:0] DELAY_I = '0;
   logic                  TRG_EVENT_I = 1'b0;
   logic                  STORE_I = 1'b0;
   logic                  LOAD_I = 1'b0;
   logic                  EN_O, MODE_O, TRG_DELAYED_O, WE_O, WRAPPED_O, BUSY_O, DONE_O;
   logic [TRB_ADDR_W-1:0] ADDR_O, TRG_ADDR_O;

   always #5 FPGA_CLK_I = ~FPGA_CLK_I;

   trace_sequencer dut (
      .FPGA_CLK_I    (FPGA_CLK_I),
      .RST_I         (RST_I),
      .ARM_I         (ARM_I),
      .STOP_I        (STOP_I),
      .MODE_I        (MODE_I),
      .DELAY_I       (DELAY_I),
      .TRG_EVENT_I   (TRG_EVENT_I),
      .STORE_I       (STORE_I),
      .LOAD_I        (LOAD_I),
      .EN_O          (EN_O),
      .MODE_O        (MODE_O),
      .TRG_DELAYED_O (TRG_DELAYED_O),
      .ADDR_O        (ADDR_O),
      .WE_O          (WE_O),
      .TRG_ADDR_O    (TRG_ADDR_O),
      .WRAPPED_O     (WRAPPED_O),
      .BUSY_O        (BUSY_O),
      .DONE_O        (DONE_O)
   );

   typedef struct {
      bit en; bit mode; bit done; bit dly; bit we; bit wrapped;
      int addr; int trg_addr;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_fail   = 0;

   int m_phase = P_IDLE, m_addr = 0, m_wrap = 0, m_trg = 0, m_cnt = 0, m_mode = 0, m_dly = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void bump();
      m_addr = (m_addr + 1) % DEPTH;
      if (m_addr == 0) m_wrap = 1;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_addr = 0; m_wrap = 0; m_trg = 0;
      m_cnt = 0; m_mode = 0; m_dly = 0;
      q.delete();
   endtask

   // Expected outputs for the current cycle, then advance the session by one clock.
   task automatic model_step();
      exp_t e;
      bit   active, we;
      active = (m_phase == P_PRE) || (m_phase == P_POST) || (m_phase == P_STREAM);
      we     = STORE_I && ((m_phase == P_PRE) || (m_phase == P_POST));
      e.en = active; e.mode = (m_mode != 0); e.done = (m_phase == P_DONE);
      e.dly = (m_dly != 0); e.we = we; e.wrapped = (m_wrap != 0);
      e.addr = m_addr; e.trg_addr = m_trg;
      q.push_back(e);
      if (!active) begin
         if (ARM_I) begin
            m_addr = 0; m_trg = 0; m_wrap = 0; m_dly = 0; m_mode = int'(MODE_I);
            m_phase = MODE_I ? P_STREAM : P_PRE;
         end
      end else if (STOP_I) begin
         if (we) bump();
         m_phase = P_DONE;
      end else begin
         case (m_phase)
            P_PRE: begin
               if (TRG_EVENT_I) begin
                  m_trg = m_addr; m_cnt = int'(DELAY_I); m_phase = P_POST;
               end
               if (we) bump();
            end
            P_POST: if (we) begin
               if (m_cnt == 0) begin
                  m_phase = P_DONE; m_dly = 1;
               end else begin
                  m_cnt--;
               end
               bump();
            end
            default: if (LOAD_I) bump();
         endcase
      end
   endtask

   // One clock: drive inputs, predict, wait past the edge.
   task automatic cycle(input int arm, input int stop, input int mode, input int dly,
                        input int trg, input int store, input int load);
      ARM_I = (arm != 0); STOP_I = (stop != 0); MODE_I = (mode != 0);
      DELAY_I = TRB_ADDR_W'(dly); TRG_EVENT_I = (trg != 0);
      STORE_I = (store != 0); LOAD_I = (load != 0);
      #1 model_step();
      @(posedge FPGA_CLK_I);
      #1;
   endtask

   always @(negedge FPGA_CLK_I) begin
      if (!RST_I && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("en",       int'(EN_O),          int'(e.en));
         chk("busy",     int'(BUSY_O),        int'(e.en));
         chk("mode",     int'(MODE_O),        int'(e.mode));
         chk("done",     int'(DONE_O),        int'(e.done));
         chk("trg_dly",  int'(TRG_DELAYED_O), int'(e.dly));
         chk("we",       int'(WE_O),          int'(e.we));
         chk("wrapped",  int'(WRAPPED_O),     int'(e.wrapped));
         chk("addr",     int'(ADDR_O),        e.addr);
         chk("trg_addr", int'(TRG_ADDR_O),    e.trg_addr);
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_en"},   int'(EN_O), 0);      chk({tag, "_busy"}, int'(BUSY_O), 0);
      chk({tag, "_done"}, int'(DONE_O), 0);    chk({tag, "_dly"},  int'(TRG_DELAYED_O), 0);
      chk({tag, "_mode"}, int'(MODE_O), 0);    chk({tag, "_we"},   int'(WE_O), 0);
      chk({tag, "_wrap"}, int'(WRAPPED_O), 0); chk({tag, "_addr"}, int'(ADDR_O), 0);
      chk({tag, "_trg"},  int'(TRG_ADDR_O), 0);
   endtask

   initial begin
      #1 chk_reset_outputs("por");
      @(posedge FPGA_CLK_I); #1 RST_I = 1'b0;
      model_reset();

      // Basic trace: trigger at word 3, four more words after it.
      cycle(1, 0, 0, 0, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 4, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("basic_last_addr", int'(ADDR_O), 7);
         cycle(0, 0, 0, 4, 1, 1, 0);
      end
      chk("basic_trg_addr", int'(TRG_ADDR_O), 3);
      chk("basic_done", int'(DONE_O), 1);
      chk("basic_dly", int'(TRG_DELAYED_O), 1);
      chk("basic_en", int'(EN_O), 0);

      // Wrap: 20 pre-trigger words, maximum delay.
      cycle(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 0, 0, 0, 1, 0);
         if (i == 14) chk("wrap_before", int'(WRAPPED_O), 0);
         if (i == 15) chk("wrap_at16", int'(WRAPPED_O), 1);
      end
      cycle(0, 0, 0, 15, 1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("wrap_last_addr", int'(ADDR_O), 3);
         cycle(0, 0, 0, 15, 1, 1, 0);
      end
      chk("wrap_trg_addr", int'(TRG_ADDR_O), 4);
      chk("wrap_done", int'(DONE_O), 1);

      // Trigger coincident with a store at word 5.
      cycle(1, 0, 0, 0, 0, 0, 0);
      repeat (5) cycle(0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 2, 1, 1, 0);
      chk("coinc_trg_addr", int'(TRG_ADDR_O), 5);
      repeat (3) cycle(0, 0, 0, 2, 1, 1, 0);
      chk("coinc_done", int'(DONE_O), 1);

      // Zero delay: only the trigger word itself is written.
      cycle(1, 0, 0, 0, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      chk("d0_trg_addr", int'(TRG_ADDR_O), 2);
      cycle(0, 0, 0, 0, 1, 1, 0);
      chk("d0_done", int'(DONE_O), 1);
      cycle(0, 0, 0, 0, 1, 1, 0);
      chk("d0_addr_frozen", int'(ADDR_O), 3);

      // Stream: 18 loads, a stray arm, then stop with a coincident load.
      cycle(1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 18; i++) cycle((i == 9) ? 1 : 0, 0, 0, 0, 1, 1, 1);
      chk("stream_addr", int'(ADDR_O), 2);
      chk("stream_wrap", int'(WRAPPED_O), 1);
      chk("stream_mode", int'(MODE_O), 1);
      cycle(0, 1, 0, 0, 1, 1, 1);
      chk("stream_done", int'(DONE_O), 1);
      chk("stream_dly", int'(TRG_DELAYED_O), 0);
      chk("stream_stop_addr", int'(ADDR_O), 2);

      // Asynchronous reset in the middle of post-trigger capture.
      cycle(1, 0, 0, 0, 0, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 10, 1, 1, 0);
      repeat (2) cycle(0, 0, 0, 10, 1, 1, 0);
      chk("pre_rst_busy", int'(BUSY_O), 1);
      STORE_I = 1'b0;
      RST_I = 1'b1;
      #1 chk_reset_outputs("midrst");
      model_reset();
      @(posedge FPGA_CLK_I); #1 RST_I = 1'b0;

      // Random sessions.
      for (int s = 0; s < 60; s++) begin
         cycle(1, 0, int'($urandom_range(0, 1)), 0, 0, 0, 0);
         for (int c = 0; c < 50 && m_phase != P_DONE; c++) begin
            cycle(($urandom_range(0, 29) == 0) ? 1 : 0,
                  ($urandom_range(0, 39) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)));
         end
         repeat (2) cycle(0, 0, 0, 0, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      end

      repeat (2) @(posedge FPGA_CLK_I);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
